// File: rtl/pong_serial_pkg.sv
// pong_serial_pkg: shared serial-link encodings, line levels and frame-length helper.
package pong_serial_pkg;
    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = TX_IDLE,
        ST_START  = TX_START,
        ST_DATA   = TX_DATA,
        ST_PARITY = TX_PARITY,
        ST_STOP   = TX_STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int frame_len(input int data_bits, input int stop_bits, input bit parity);
        return 1 + data_bits + int'(parity) + stop_bits;
    endfunction
endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: synchronous FIFO with push/pop, registered full/empty flags and occupancy count.
module serial_tx_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic wen;
    logic ren;
    logic [CW-1:0] count_next;

    assign wen = push && !full;
    assign ren = pop && !empty;
    assign count_next = count + CW'(wen) - CW'(ren);
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk)
        if (wen) mem[wr_ptr] <= din;

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wen);
            rd_ptr <= rd_ptr + AW'(ren);
            count  <= count_next;
            full   <= count_next == CW'(DEPTH);
            empty  <= count_next == '0;
        end
    end
endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: FIFO-buffered UART-style transmitter, LSB first, one bit per clock.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module serial_transmitter
    import pong_serial_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                 bounderClock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] datain,
    input  logic                 IN_LOAD,
    output logic                 txbit,
    output logic                 OUT_STATUS_BUSY,
    output logic                 OUT_STATUS_FULL,
    output logic                 OUT_STATUS_OVERRUN
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_BITS + STOP_BITS + 1);

    tx_state_t state;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic stop_last;
    logic idle_next;
`ifdef SERIAL_TX_PARITY_EN
    logic par;
`endif

    assign push = IN_LOAD && !full;
    assign stop_last = state == ST_STOP && bit_cnt == BW'(STOP_BITS - 1);
    assign pop = !empty && (state == ST_IDLE || stop_last);
    assign idle_next = empty && (state == ST_IDLE || stop_last);
    assign count_next = count + CW'(push) - CW'(pop);
    assign OUT_STATUS_FULL = full;

    serial_tx_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (bounderClock),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (datain),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            txbit              <= LINE_IDLE;
            sh                 <= '0;
            bit_cnt            <= '0;
            OUT_STATUS_BUSY    <= 1'b0;
            OUT_STATUS_OVERRUN <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par                <= 1'b0;
`endif
        end else begin
            OUT_STATUS_OVERRUN <= OUT_STATUS_OVERRUN || (IN_LOAD && full);
            OUT_STATUS_BUSY    <= !(idle_next && count_next == '0);
            case (state)
                // the last stop cycle chains straight into the next start bit
                ST_IDLE, ST_STOP: begin
                    if (pop) begin
                        sh      <= fifo_dout;
                        txbit   <= START_BIT;
                        bit_cnt <= '0;
                        state   <= ST_START;
`ifdef SERIAL_TX_PARITY_EN
                        par     <= ^fifo_dout;
`endif
                    end else if (state == ST_STOP && !stop_last) begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end else begin
                        txbit <= LINE_IDLE;
                        state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    txbit   <= sh[0];
                    bit_cnt <= '0;
                    state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        txbit   <= par;
                        state   <= ST_PARITY;
`else
                        txbit   <= STOP_BIT;
                        state   <= ST_STOP;
`endif
                    end else begin
                        sh      <= sh >> 1;
                        txbit   <= sh[1];
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    txbit   <= STOP_BIT;
                    bit_cnt <= '0;
                    state   <= ST_STOP;
                end
`endif
                default: begin
                    txbit <= LINE_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
